// File: rtl/winocnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : winocnn_pkg
// Purpose  : Shared tile geometry, data types and collector state encoding.
// Revision : 1.0
// ============================================================================
package winocnn_pkg;

    localparam int TILE   = 6;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 9;
    localparam int OD_W   = 8;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef data_t [0:TILE-1][0:TILE-1] tile_t;
    typedef data_t [0:TILE-1] row_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } coll_state_e;

endpackage
`default_nettype wire

// File: rtl/pe_result_collector_sat_shift.sv
`default_nettype none
// ============================================================================
// Module   : sat_shift
// Purpose  : Arithmetic right shift of one accumulator lane, saturated to 16 bits.
// Revision : 1.0
// ============================================================================
module sat_shift
    import winocnn_pkg::*;
#(
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output data_t                   sat
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> OUT_SHIFT;
        if (shifted > SAT_MAX) begin
            sat = 16'sh7FFF;
        end else if (shifted < SAT_MIN) begin
            sat = 16'sh8000;
        end else begin
            sat = shifted[DATA_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : pe_result_collector
// Purpose  : Sums NUM_IC matching 6x6 PE tiles, then drains the saturated
//            result one row per cycle to the output-buffer write port.
// Revision : 1.0
// ============================================================================
module pe_result_collector
    import winocnn_pkg::*;
#(
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       num_ic_i,
    input  tile_t            result_tile_i,
    input  logic [OD_W-1:0]  result_od_i,
    input  logic [IDX_W-1:0] result_x_index_i,
    input  logic [IDX_W-1:0] result_y_index_i,
    input  logic             result_valid_i,
    output logic             result_ready_o,
    output row_t             wr_row_o,
    output logic [OD_W-1:0]  wr_od_o,
    output logic [IDX_W-1:0] wr_x_o,
    output logic [IDX_W-1:0] wr_y_o,
    output logic             wr_valid_o,
    input  logic             wr_ready_i,
    output logic             wr_last_o,
    output logic             err_o
);

    typedef logic signed [ACC_W-1:0] acc_t;

    coll_state_e      state;
    coll_state_e      state_next;
    acc_t             acc [0:TILE-1][0:TILE-1];
    logic [7:0]       cnt;
    logic [7:0]       num_ic_cap;
    logic [OD_W-1:0]  od_cap;
    logic [IDX_W-1:0] x_cap;
    logic [IDX_W-1:0] y_cap;
    logic [2:0]       row;
    logic             err;

    logic             accept;
    logic             row_hs;
    logic             idx_match;
    logic [7:0]       num_ic_eff;
    logic [7:0]       cnt_inc;

    assign accept     = result_valid_i && result_ready_o;
    assign row_hs     = wr_valid_o && wr_ready_i;
    assign idx_match  = (result_od_i == od_cap) && (result_x_index_i == x_cap) &&
                        (result_y_index_i == y_cap);
    assign num_ic_eff = (num_ic_i == 8'd0) ? 8'd1 : num_ic_i;
    // cnt < num_ic_cap <= 255 while accumulating, so the increment cannot wrap.
    assign cnt_inc    = cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (num_ic_eff == 8'd1) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && idx_match && (cnt_inc == num_ic_cap)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (row_hs && (row == 3'd5)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        result_ready_o = (state != DRAIN) && !reset;
        wr_valid_o     = (state == DRAIN);
        wr_last_o      = (state == DRAIN) && (row == 3'd5);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TILE; i++) begin
                for (int j = 0; j < TILE; j++) begin
                    acc[i][j] <= '0;
                end
            end
            cnt        <= '0;
            num_ic_cap <= '0;
            od_cap     <= '0;
            x_cap      <= '0;
            y_cap      <= '0;
            row        <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < TILE; i++) begin
                            for (int j = 0; j < TILE; j++) begin
                                acc[i][j] <= ACC_W'($signed(result_tile_i[i][j]));
                            end
                        end
                        od_cap     <= result_od_i;
                        x_cap      <= result_x_index_i;
                        y_cap      <= result_y_index_i;
                        num_ic_cap <= num_ic_eff;
                        cnt        <= 8'd1;
                        row        <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (idx_match) begin
                            for (int i = 0; i < TILE; i++) begin
                                for (int j = 0; j < TILE; j++) begin
                                    acc[i][j] <= acc[i][j] +
                                                 ACC_W'($signed(result_tile_i[i][j]));
                                end
                            end
                            cnt <= cnt_inc;
                        end else begin
                            // Foreign tile: consumed so the PE never stalls, but flagged.
                            err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (row_hs) begin
                        if (row == 3'd5) begin
                            row <= '0;
                            cnt <= '0;
                        end else begin
                            row <= row + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign err_o   = err;
    assign wr_od_o = od_cap;
    assign wr_x_o  = x_cap;
    assign wr_y_o  = y_cap + IDX_W'(row);

    for (genvar j = 0; j < TILE; j++) begin : g_col
        sat_shift #(
            .ACC_W     (ACC_W),
            .OUT_SHIFT (OUT_SHIFT)
        ) u_sat (
            .acc (acc[row][j]),
            .sat (wr_row_o[j])
        );
    end

endmodule
`default_nettype wire
